branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_W, default 32: instruction address width.
REQ-002 Parameter BTB_ENTRIES, default 16, power of two >= 2: direct-mapped entry count; IDX_W = log2(BTB_ENTRIES).
REQ-003 Parameter CNT_W, default 2, range 1..4: saturating direction counter width.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 if_pc  in  ADDR_W: fetch-stage lookup address.
REQ-007 pred_taken  out  1: lookup predicts taken.
REQ-008 pred_target  out  ADDR_W: predicted next fetch address.
REQ-009 upd_valid  in  1: ID stage presents a resolved instruction this cycle.
REQ-010 upd_pc, upd_target  in  ADDR_W: resolved instruction address and branch/jump target.
REQ-011 upd_is_branch, upd_taken  in  1: instruction is branch/jump; resolved direction.
REQ-012 id_pred_taken, id_pred_target  in  1/ADDR_W: prediction made for that instruction at fetch, carried down the pipeline.
REQ-013 redirect_valid  out  1: misprediction; fetch is restarted at redirect_pc.
REQ-014 redirect_pc  out  ADDR_W: corrected fetch address.
REQ-015 stat_branches, stat_mispredicts  out  32: event counters (present only under REQ-032).

Function
REQ-016 Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; each entry holds valid, tag, target, CNT_W-bit counter.
REQ-017 Lookup is combinational from registered state: hit = valid & tag match; pred_taken = hit & counter MSB; pred_target = pred_taken ? entry target : if_pc+4 (modulo 2^ADDR_W).
REQ-018 Update is written on the rising edge after upd_valid=1; a same-cycle lookup of the same index sees the pre-update contents (no bypass).
REQ-019 Branch, hit: counter saturating +1 if taken, -1 if not taken; target overwritten with upd_target only when taken.
REQ-020 Branch, miss, taken: allocate (overwrite) entry, valid=1, tag, target, counter = weakly taken (MSB=1, other bits 0).
REQ-021 Branch, miss, not taken: no write.
REQ-022 Non-branch whose index/tag hits: clear valid (alias removal).
REQ-023 redirect_valid is combinational, asserted when upd_valid and any of: upd_is_branch & (upd_taken != id_pred_taken); upd_is_branch & upd_taken & id_pred_taken & (upd_target != id_pred_target); !upd_is_branch & id_pred_taken.
REQ-024 redirect_pc: upd_target if branch taken; upd_pc+8 (past delay slot) if branch not taken; upd_pc+4 for non-branch.
REQ-025 upd_valid=0: no state change, redirect_valid=0, redirect_pc=0.
REQ-026 Counter saturates at 0 and 2^CNT_W-1; never wraps.

Reset
REQ-027 rst_n low asynchronously clears all valid bits, sets all counters to weakly not-taken (MSB=0, other bits 1), targets and tags to 0.
REQ-028 During reset pred_taken=0, pred_target=if_pc+4, redirect_valid=0, redirect_pc=0, stat counters 0.
REQ-029 Reset asserted mid-update discards the update; first edge after release performs no write unless upd_valid=1.

Configuration
REQ-030 Macro BP_STATS_EN selects statistics counters.
REQ-031 Without BP_STATS_EN: stat ports and their registers absent; all other behaviour identical.
REQ-032 With BP_STATS_EN: stat_branches +1 per edge with upd_valid & upd_is_branch; stat_mispredicts +1 per edge with redirect_valid; both wrap at 2^32.

Verification
REQ-033 After reset, if_pc=0x00400000 -> pred_taken=0, pred_target=0x00400004.
REQ-034 Update pc=0x00400010 taken target 0x00400040 with id_pred_taken=0 -> redirect_valid=1, redirect_pc=0x00400040; next cycle lookup 0x00400010 -> pred_taken=1, pred_target=0x00400040.
REQ-035 Same branch then resolved not-taken twice (CNT_W=2) -> counter 10->01->00, pred_taken=0; first not-taken update redirects to 0x00400018.
REQ-036 Alias: 16 entries, entry for 0x00400010 allocated; non-branch update pc=0x00400050 with matching index but different tag -> no write, no redirect; non-branch update pc=0x00400010 with id_pred_taken=1 -> redirect_pc=0x00400014, entry invalidated.
REQ-037 Same-cycle lookup and update of same index -> lookup returns old prediction, new one visible next cycle.
REQ-038 BP_STATS_EN defined: 5 branch updates, 2 mispredicted -> stat_branches=5, stat_mispredicts=2; rst_n pulsed low mid-sequence -> both 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch looks up the BTB combinationally; the ID stage feeds back
// resolved instructions, which update the BTB on the next rising edge and
// raise a combinational redirect when the fetch-time prediction was wrong.
//
// Parameters
//   ADDR_W       instruction address width
//   BTB_ENTRIES  number of direct-mapped entries (power of two, >= 2)
//   CNT_W        direction counter width (1..4)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_pc                      fetch lookup address
//   pred_taken, pred_target    lookup result (target = if_pc+4 when not taken)
//   upd_valid                  resolved instruction present this cycle
//   upd_pc, upd_target         resolved instruction address and target
//   upd_is_branch, upd_taken   branch/jump flag and resolved direction
//   id_pred_taken,
//   id_pred_target             prediction made for it at fetch
//   redirect_valid,
//   redirect_pc                misprediction restart request
//   stat_branches,
//   stat_mispredicts           event counters (only with BP_STATS_EN)
//
// Build option
//   BP_STATS_EN  when defined, adds the two 32-bit statistics counters and
//                their output ports.
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic              id_pred_taken,
    input  logic [ADDR_W-1:0] id_pred_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
   ,output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // Weakly taken: MSB set, remaining bits clear.
    localparam logic [CNT_W-1:0]  CNT_WTAKE = CNT_W'(2 ** (CNT_W - 1));
    // Weakly not-taken: MSB clear, remaining bits set.
    localparam logic [CNT_W-1:0]  CNT_WNOT  = CNT_MAX >> 1;

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_SKIP   = ADDR_W'(8);

    // ------------------------------------------------------------------
    // BTB storage
    // ------------------------------------------------------------------
    logic              valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_q [BTB_ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [BTB_ENTRIES];

    // Word-offset bits take no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Fetch lookup (reads registered state only, no update bypass)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Reset clears every valid bit asynchronously, so pred_taken drops to 0
    // during reset without explicit gating.
    assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + PC_STEP);

    // ------------------------------------------------------------------
    // Update: next-state of the single entry addressed by upd_pc
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;

    logic              wr_en;
    logic              wr_valid_d;
    logic [TAG_W-1:0]  wr_tag_d;
    logic [ADDR_W-1:0] wr_target_d;
    logic [CNT_W-1:0]  wr_cnt_d;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en       = 1'b0;
        wr_valid_d  = valid_q[up_idx];
        wr_tag_d    = tag_q[up_idx];
        wr_target_d = target_q[up_idx];
        wr_cnt_d    = cnt_q[up_idx];

        if (upd_valid) begin
            if (upd_is_branch) begin
                if (up_hit) begin
                    wr_en = 1'b1;
                    if (upd_taken) begin
                        wr_target_d = upd_target;
                        if (cnt_q[up_idx] != CNT_MAX) begin
                            wr_cnt_d = cnt_q[up_idx] + CNT_W'(1);
                        end
                    end else if (cnt_q[up_idx] != '0) begin
                        wr_cnt_d = cnt_q[up_idx] - CNT_W'(1);
                    end
                end else if (upd_taken) begin
                    wr_en       = 1'b1;
                    wr_valid_d  = 1'b1;
                    wr_tag_d    = up_tag;
                    wr_target_d = upd_target;
                    wr_cnt_d    = CNT_WTAKE;
                end
            end else if (up_hit) begin
                // A non-branch that matches an entry means the entry is a
                // stale alias; drop it so it stops steering fetch.
                wr_en      = 1'b1;
                wr_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[IDX_W'(i)]  <= 1'b0;
                tag_q[IDX_W'(i)]    <= '0;
                target_q[IDX_W'(i)] <= '0;
                cnt_q[IDX_W'(i)]    <= CNT_WNOT;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= wr_valid_d;
            tag_q[up_idx]    <= wr_tag_d;
            target_q[up_idx] <= wr_target_d;
            cnt_q[up_idx]    <= wr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Misprediction detection and redirect
    // ------------------------------------------------------------------
    logic mispredict;

    always_comb begin
        if (upd_is_branch) begin
            mispredict = (upd_taken != id_pred_taken) ||
                         (upd_taken && id_pred_taken && (upd_target != id_pred_target));
        end else begin
            mispredict = id_pred_taken;
        end
    end

    // Gated by rst_n so both outputs read 0 while reset is held.
    assign redirect_valid = rst_n && upd_valid && mispredict;

    always_comb begin
        redirect_pc = '0;
        if (rst_n && upd_valid) begin
            if (!upd_is_branch) begin
                redirect_pc = upd_pc + PC_STEP;
            end else if (upd_taken) begin
                redirect_pc = upd_target;
            end else begin
                // Not-taken branch resumes past its delay slot.
                redirect_pc = upd_pc + PC_SKIP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (upd_valid && upd_is_branch) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (redirect_valid) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule
